// File: rtl/gb_timer.sv
// DMG timer/divider (DIV/TIMA/TMA/TAC at FF04h-FF07h): reads are combinational, writes land on the next clock.
// TIMA overflow holds 00h for four ce cycles, then reloads from TMA with a one-ce-cycle irq pulse.
module gb_timer #(
    parameter int TCYCLE_DIV = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] A,
    input  logic [7:0]  Di,
    output logic [7:0]  Do,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        cs,
    output logic        irq
);

    typedef enum logic [1:0] {
        RUN = 2'd0,
        OVF = 2'd1,
        RLD = 2'd2
    } state_t;

    localparam int CW = (TCYCLE_DIV > 1) ? $clog2(TCYCLE_DIV) : 1;

    state_t      state;
    logic [15:0] div_cnt;
    logic [7:0]  tima;
    logic [7:0]  tma;
    logic [2:0]  tac;
    logic [1:0]  dly;
    logic        prev_sel;
    logic        ce;
    logic        tick_bit;
    logic        sel;
    logic        inc_evt;
    logic        wr_div;
    logic        wr_tima;
    logic        wr_tma;
    logic        wr_tac;
    logic        unused_addr;

    assign unused_addr = ^A[15:2];

    generate
        if (TCYCLE_DIV > 1) begin : g_ce_div
            logic [CW-1:0] ce_cnt;
            always_ff @(posedge clock) begin
                if (reset) begin
                    ce_cnt <= '0;
                end else if (ce_cnt == CW'(TCYCLE_DIV - 1)) begin
                    ce_cnt <= '0;
                end else begin
                    ce_cnt <= ce_cnt + 1'b1;
                end
            end
            assign ce = (ce_cnt == CW'(TCYCLE_DIV - 1));
        end else begin : g_ce_one
            assign ce = 1'b1;
        end
    endgenerate

    assign wr_div  = cs && !wr_n && (A[1:0] == 2'd0);
    assign wr_tima = cs && !wr_n && (A[1:0] == 2'd1);
    assign wr_tma  = cs && !wr_n && (A[1:0] == 2'd2);
    assign wr_tac  = cs && !wr_n && (A[1:0] == 2'd3);

    always_comb begin
        tick_bit = div_cnt[9];
        case (tac[1:0])
            2'd0: tick_bit = div_cnt[9];
            2'd1: tick_bit = div_cnt[3];
            2'd2: tick_bit = div_cnt[5];
            2'd3: tick_bit = div_cnt[7];
            default: tick_bit = div_cnt[9];
        endcase
    end

    // Edge detect runs every clock so DIV clears and TAC changes glitch TIMA like the real part.
    assign sel     = tick_bit && tac[2];
    assign inc_evt = prev_sel && !sel;

    always_comb begin
        Do = 8'hFF;
        if (cs && !rd_n) begin
            case (A[1:0])
                2'd0: Do = div_cnt[15:8];
                2'd1: Do = tima;
                2'd2: Do = tma;
                2'd3: Do = {5'b11111, tac};
                default: Do = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= RUN;
            div_cnt  <= 16'h0000;
            tima     <= 8'h00;
            tma      <= 8'h00;
            tac      <= 3'b000;
            dly      <= 2'd0;
            prev_sel <= 1'b0;
            irq      <= 1'b0;
        end else begin
            prev_sel <= sel;

            if (wr_div) begin
                div_cnt <= 16'h0000;
            end else if (ce) begin
                div_cnt <= div_cnt + 16'd1;
            end

            if (wr_tma) begin
                tma <= Di;
            end
            if (wr_tac) begin
                tac <= Di[2:0];
            end
            if (ce) begin
                irq <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (wr_tima) begin
                        tima <= Di;
                    end else if (inc_evt) begin
                        if (tima == 8'hFF) begin
                            tima  <= 8'h00;
                            dly   <= 2'd3;
                            state <= OVF;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
                OVF: begin
                    // A CPU write here aborts the pending reload and its interrupt.
                    if (wr_tima) begin
                        tima  <= Di;
                        state <= RUN;
                    end else if (ce) begin
                        if (dly == 2'd0) begin
                            tima  <= tma;
                            irq   <= 1'b1;
                            state <= RLD;
                        end else begin
                            dly <= dly - 2'd1;
                        end
                    end
                end
                RLD: begin
                    if (wr_tma) begin
                        tima <= Di;
                    end
                    if (ce) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
